// File: rtl/instr_mem_writer.sv
// Instruction encoder/loader: packs R/I/J fields into a MIPS word and writes it at an auto-incrementing address.
// Optional macro INSTR_MEM_WRITER_CHECK_EN enforces format/opcode consistency.
module instr_mem_writer #(
    parameter int unsigned             ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]       BASE_ADDR = '0,
    parameter int unsigned             DEPTH     = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        fmt_i,
    input  logic [5:0]        op_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic              mem_ack_i,
    output logic [7:0]        count_o,
    output logic              full_o,
    output logic              err_o
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t              state, state_n;
    logic                we_n, err_n, legal;
    logic [ADDR_W-1:0]   addr_n;
    logic [31:0]         data_n, word;
    logic [7:0]          count_n;

    assign full_o  = (count_o == 8'(DEPTH));
    assign ready_o = (state == IDLE) && !full_o;

    always_comb begin
        word = '0;
        case (fmt_i)
            2'd0:    word = {op_i, rs_i, rt_i, rd_i, shamt_i, funct_i};
            2'd1:    word = {op_i, rs_i, rt_i, imm_i};
            2'd2:    word = {op_i, target_i};
            default: word = '0;
        endcase
    end

`ifdef INSTR_MEM_WRITER_CHECK_EN
    always_comb begin
        legal = 1'b0;
        case (fmt_i)
            2'd0: legal = (op_i == 6'd0);
            2'd1: legal = (op_i inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9,
                                        6'd13, 6'd15, 6'd35, 6'd43});
            2'd2: legal = (op_i == 6'd2) || (op_i == 6'd3);
            default: legal = 1'b0;
        endcase
    end
`else
    assign legal = (fmt_i != 2'd3);
`endif

    // start_i overrides every transition, including an ack in the same cycle
    always_comb begin
        state_n = state;
        we_n    = mem_we_o;
        addr_n  = mem_addr_o;
        data_n  = mem_data_o;
        count_n = count_o;
        err_n   = err_o;
        if (start_i) begin
            state_n = IDLE;
            we_n    = 1'b0;
            addr_n  = BASE_ADDR;
            count_n = '0;
            err_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        if (legal) begin
                            data_n  = word;
                            we_n    = 1'b1;
                            state_n = WRITE;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack_i) begin
                        we_n    = 1'b0;
                        addr_n  = mem_addr_o + ADDR_W'(4);
                        count_n = count_o + 8'd1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            mem_we_o   <= 1'b0;
            mem_addr_o <= BASE_ADDR;
            mem_data_o <= '0;
            count_o    <= '0;
            err_o      <= 1'b0;
        end else begin
            state      <= state_n;
            mem_we_o   <= we_n;
            mem_addr_o <= addr_n;
            mem_data_o <= data_n;
            count_o    <= count_n;
            err_o      <= err_n;
        end
    end

endmodule

// File: tb/tb_instr_mem_writer.sv
// Randomized self-checking bench for instr_mem_writer against a field-packing / address-counting model.
module tb_instr_mem_writer;
    localparam int DEPTH = 4;

    logic        clk = 0, rst_n = 0, start = 0, valid = 0, ack = 0;
    logic [1:0]  fmt = 0;
    logic [5:0]  op = 0, funct = 0;
    logic [4:0]  rs = 0, rt = 0, rd = 0, shamt = 0;
    logic [15:0] imm = 0;
    logic [25:0] target = 0;
    logic        ready, we, full, err;
    logic [31:0] addr, data;
    logic [7:0]  count;

    int checks = 0, failures = 0;
    int m_count = 0;

    instr_mem_writer #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .valid_i(valid), .ready_o(ready),
        .fmt_i(fmt), .op_i(op), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt),
        .funct_i(funct), .imm_i(imm), .target_i(target),
        .mem_we_o(we), .mem_addr_o(addr), .mem_data_o(data), .mem_ack_i(ack),
        .count_o(count), .full_o(full), .err_o(err)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic packing and opcode tables
    function automatic logic [31:0] model_word();
        longint w;
        case (fmt)
            2'd0: w = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536
                      + rd * 64'd2048 + shamt * 64'd64 + funct;
            2'd1: w = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
            default: w = op * 64'd67108864 + target;
        endcase
        return 32'(w);
    endfunction

    function automatic bit model_legal();
        if (fmt == 3) return 0;
`ifdef INSTR_MEM_WRITER_CHECK_EN
        if (fmt == 0) return op == 0;
        if (fmt == 2) return op == 2 || op == 3;
        return op == 1 || op == 4 || op == 5 || op == 6 || op == 8 || op == 9 ||
               op == 13 || op == 15 || op == 35 || op == 43;
`else
        return 1;
`endif
    endfunction

    function automatic logic [31:0] model_addr();
        return 32'(4 * m_count);
    endfunction

    task automatic set_fields(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                              input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                              input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
        fmt = f; op = o; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; target = tg;
    endtask

    // Present fields for exactly one edge; returns at the following negedge
    task automatic issue();
        @(negedge clk); valid = 1;
        @(negedge clk); valid = 0;
    endtask

    task automatic do_ack();
        ack = 1;
        @(negedge clk); ack = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        m_count = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #3;
        checks++;
        if (we !== 0 || addr !== 0 || data !== 0 || count !== 0 || err !== 0 || ready !== 1 || full !== 0) begin
            failures++;
            $display("FAIL reset: we=%b addr=%h data=%h count=%0d err=%b ready=%b full=%b, want 0/0/0/0/0/1/0",
                     we, addr, data, count, err, ready, full);
        end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_directed();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h21090005; exp_w[1] = 32'h00221820; exp_w[2] = 32'h08000100;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_fields(1, 8, 8, 9, 0, 0, 0, 16'd5, 0);
            else if (i == 1) set_fields(0, 0, 1, 2, 3, 0, 6'h20, 0, 0);
            else set_fields(2, 2, 0, 0, 0, 0, 0, 0, 26'h100);
            issue();
            checks++;
            if (we !== 1 || data !== exp_w[i] || addr !== model_addr() || ready !== 0) begin
                failures++;
                $display("FAIL directed_write%0d: we=%b data=%h addr=%h ready=%b, want 1/%h/%h/0",
                         i, we, data, addr, ready, exp_w[i], model_addr());
            end
            do_ack();
            m_count++;
            checks++;
            if (we !== 0 || count !== 8'(m_count) || addr !== model_addr() || ready !== 1) begin
                failures++;
                $display("FAIL directed_ack%0d: we=%b count=%0d addr=%h ready=%b, want 0/%0d/%h/1",
                         i, we, count, addr, ready, m_count, model_addr());
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] a0;
        pulse_start();
        a0 = model_addr();
        set_fields(3, 8, 1, 2, 3, 4, 5, 6, 7);
        issue();
        checks++;
        if (err !== 1 || we !== 0 || addr !== a0 || count !== 0 || ready !== 1) begin
            failures++;
            $display("FAIL illegal_fmt3: err=%b we=%b addr=%h count=%0d ready=%b, want 1/0/%h/0/1",
                     err, we, addr, count, ready, a0);
        end
        pulse_start();
        set_fields(0, 8, 1, 2, 3, 0, 6'h20, 0, 0);
        issue();
        checks++;
        if (model_legal()) begin
            if (we !== 1 || data !== model_word() || err !== 0) begin
                failures++;
                $display("FAIL r_op8_write: we=%b data=%h err=%b, want 1/%h/0", we, data, err, model_word());
            end
            do_ack();
            m_count++;
        end else if (err !== 1 || we !== 0 || addr !== a0 || ready !== 1) begin
            failures++;
            $display("FAIL r_op8_reject: err=%b we=%b addr=%h ready=%b, want 1/0/%h/1", err, we, addr, ready, a0);
        end
    endtask

    task automatic test_stall_start_ack();
        logic [31:0] w;
        pulse_start();
        set_fields(1, 35, 4, 5, 0, 0, 0, 16'hbeef, 0);
        w = model_word();
        issue();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (we !== 1 || data !== w || addr !== 0 || count !== 0) begin
                failures++;
                $display("FAIL stall_hold%0d: we=%b data=%h addr=%h count=%0d, want 1/%h/0/0", i, we, data, addr, count, w);
            end
            @(negedge clk);
        end
        start = 1; ack = 1;
        @(negedge clk); start = 0; ack = 0;
        checks++;
        if (we !== 0 || count !== 0 || addr !== 0 || ready !== 1) begin
            failures++;
            $display("FAIL start_with_ack: we=%b count=%0d addr=%h ready=%b, want 0/0/0/1", we, count, addr, ready);
        end
        m_count = 0;
    endtask

    task automatic test_full();
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            set_fields(2, 3, 0, 0, 0, 0, 0, 0, 26'(i + 1));
            issue();
            do_ack();
            m_count++;
        end
        checks++;
        if (full !== 1 || ready !== 0 || count !== 8'(DEPTH) || addr !== model_addr()) begin
            failures++;
            $display("FAIL full_flag: full=%b ready=%b count=%0d addr=%h, want 1/0/%0d/%h",
                     full, ready, count, addr, DEPTH, model_addr());
        end
        valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (we !== 0 || count !== 8'(DEPTH)) begin
                failures++;
                $display("FAIL full_ignore%0d: we=%b count=%0d, want 0/%0d", i, we, count, DEPTH);
            end
        end
        start = 1;
        @(negedge clk); start = 0;
        checks++;
        if (full !== 0 || addr !== 0 || we !== 0 || count !== 0 || ready !== 1) begin
            failures++;
            $display("FAIL full_restart: full=%b addr=%h we=%b count=%0d ready=%b, want 0/0/0/0/1",
                     full, addr, we, count, ready);
        end
        valid = 0;
        m_count = 0;
    endtask

    task automatic test_random();
        int ops [10] = '{1, 4, 5, 6, 8, 9, 13, 15, 35, 43};
        logic m_err;
        pulse_start();
        m_err = 0;
        for (int n = 0; n < 60; n++) begin
            if (m_count == DEPTH) begin
                checks++;
                if (full !== 1 || ready !== 0) begin
                    failures++;
                    $display("FAIL rand_full: full=%b ready=%b, want 1/0", full, ready);
                end
                pulse_start();
                m_err = 0;
            end
            fmt = 2'($urandom_range(0, 3));
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); shamt = 5'($urandom);
            funct = 6'($urandom); imm = 16'($urandom); target = 26'($urandom);
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else if (fmt == 0) op = 0;
            else if (fmt == 2) op = 6'($urandom_range(2, 3));
            else op = 6'(ops[$urandom_range(0, 9)]);
            issue();
            if (model_legal()) begin
                checks++;
                if (we !== 1 || data !== model_word() || addr !== model_addr() || err !== m_err) begin
                    failures++;
                    $display("FAIL rand_write%0d: we=%b data=%h addr=%h err=%b, want 1/%h/%h/%b",
                             n, we, data, addr, err, model_word(), model_addr(), m_err);
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                do_ack();
                m_count++;
                checks++;
                if (we !== 0 || count !== 8'(m_count) || addr !== model_addr()) begin
                    failures++;
                    $display("FAIL rand_ack%0d: we=%b count=%0d addr=%h, want 0/%0d/%h",
                             n, we, count, addr, m_count, model_addr());
                end
            end else begin
                m_err = 1;
                checks++;
                if (err !== 1 || we !== 0 || count !== 8'(m_count) || addr !== model_addr()) begin
                    failures++;
                    $display("FAIL rand_reject%0d: err=%b we=%b count=%0d addr=%h, want 1/0/%0d/%h",
                             n, err, we, count, addr, m_count, model_addr());
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        pulse_start();
        set_fields(0, 0, 3, 4, 5, 6, 6'h21, 0, 0);
        issue();
        do_ack();
        set_fields(1, 9, 3, 4, 0, 0, 0, 16'h1234, 0);
        issue();
        #2 rst_n = 0;
        #1;
        checks++;
        if (we !== 0 || addr !== 0 || count !== 0 || data !== 0 || err !== 0) begin
            failures++;
            $display("FAIL async_reset: we=%b addr=%h count=%0d data=%h err=%b, want 0/0/0/0/0",
                     we, addr, count, data, err);
        end
        #1 rst_n = 1;
        @(negedge clk);
        checks++;
        if (ready !== 1 || we !== 0) begin
            failures++;
            $display("FAIL after_reset: ready=%b we=%b, want 1/0", ready, we);
        end
        m_count = 0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_stall_start_ack();
        test_full();
        test_random();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
